// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   INSTR_W       - instruction / address width
//   NOP_INSTR     - filler instruction carried by a misaligned-target fault entry
//   PC_INCR       - sequential fetch stride
//   fetch_entry_t - {pc, instr, misalign} record stored in the fetch queues
//   align_pc()    - clears the byte-offset bits of a target address
package fetch_pkg;

    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INCR   = 32'd4;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
        logic               misalign;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of fetch_entry_t records.
//   clk, rst           - clock, asynchronous active-high reset
//   flush              - empty the queue; a push in the same cycle lands as the sole entry
//   push, push_data    - write one entry (ignored when full unless a pop frees a slot)
//   pop                - drop the head entry (ignored when empty)
//   head               - current head entry, straight from storage registers
//   full, empty, count - occupancy status
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] wr_idx_s;
    logic [AW:0]   count_q, count_d;
    logic          do_pop_s;
    logic          wr_en_s;

    // Next pointers and occupancy; flush restarts at slot 0 and may take one write there.
    always_comb begin
        do_pop_s = pop && (count_q != CNT_ZERO);
        wr_en_s  = 1'b0;
        wr_idx_s = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = PTR_ZERO;
            wr_idx_s = PTR_ZERO;
            wr_en_s  = push;
            if (push) begin
                wr_ptr_d = PTR_ONE;
                count_d  = CNT_ONE;
            end else begin
                wr_ptr_d = PTR_ZERO;
                count_d  = CNT_ZERO;
            end
        end else begin
            wr_en_s = push && ((count_q != CNT_FULL) || do_pop_s);
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (wr_en_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            case ({wr_en_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= PTR_ZERO;
            wr_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_q[wr_idx_s] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == CNT_ZERO);
    assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage feeding decode.
// Keeps the PC, issues in-order word requests to instruction memory under a credit
// limit of DEPTH (outstanding + buffered), buffers returned words with their PCs and
// presents them to decode over valid/ready. A redirect flushes buffered work, drops the
// responses still in flight and restarts fetch at the target.
// Optional feature macro: INSTR_FETCH_MISALIGN_EN -- a redirect to a non-word-aligned
// target yields one fault entry (pc = target, NOP, if_misalign = 1) and halts fetch
// until the next redirect or reset. Without it the target's low bits are cleared.
// Ports:
//   clk, reset                      - clock, asynchronous active-high reset
//   imem_req_valid/ready/addr       - request channel to instruction memory
//   imem_rsp_valid/data             - in-order response channel
//   redirect_valid/pc               - taken branch / jump from execute
//   if_valid/ready, if_pc/instr     - (pc, instr) handshake to decode
//   if_misalign                     - head entry is a misaligned-target fault
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_misalign
);

    localparam int                CW        = $clog2(DEPTH) + 1;
    localparam int                TW        = CW + 1;
    localparam int                DROP_W    = 16;
    localparam logic [TW-1:0]     DEPTH_T   = TW'(DEPTH);
    localparam logic [DROP_W-1:0] DROP_ZERO = 16'd0;
    localparam logic [DROP_W-1:0] DROP_ONE  = 16'd1;

    logic [31:0]       pc_q, pc_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [DROP_W-1:0] pending_s;
    logic              halted_s;
    logic              misalign_redirect_s;
    logic              pop_now_s;
    logic [TW-1:0]     in_use_s;
    logic              req_valid_s;
    logic              req_fire_s;
    logic              rsp_accept_s;

    fetch_entry_t      req_entry_s, req_head_s;
    fetch_entry_t      rsp_entry_s, mis_entry_s;
    fetch_entry_t      data_push_entry_s, data_head_s;
    logic              data_push_s, data_pop_s;
    logic              data_full_s, data_empty_s;
    logic [CW-1:0]     data_cnt_s;
    logic              req_full_s, req_empty_s;
    logic [CW-1:0]     req_cnt_s;

`ifdef INSTR_FETCH_MISALIGN_EN
    logic halted_q, halted_d;

    // Halt tracking: a misaligned redirect halts fetch, any aligned redirect resumes it.
    always_comb begin
        misalign_redirect_s = redirect_valid && (redirect_pc[1:0] != 2'b00);
        halted_s            = halted_q;
        if (redirect_valid) begin
            halted_d = misalign_redirect_s;
        end else begin
            halted_d = halted_q;
        end
    end

    // Halt flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end
`else
    // Without the fault feature a redirect never halts fetch.
    always_comb begin
        misalign_redirect_s = 1'b0;
        halted_s            = 1'b0;
    end
`endif

    // Request issue, response routing, PC and drop-counter update.
    always_comb begin
        pop_now_s = !data_empty_s && if_ready;
        // A slot being popped this cycle is already free for a new request; this is
        // what sustains one instruction per cycle with DEPTH = 2.
        in_use_s    = TW'(req_cnt_s) + TW'(data_cnt_s) - TW'(pop_now_s);
        req_valid_s = (in_use_s < DEPTH_T) && !req_full_s && !redirect_valid
                      && !halted_s && !reset;
        req_fire_s  = req_valid_s && imem_req_ready;

        rsp_accept_s = imem_rsp_valid && (drop_q == DROP_ZERO) && !req_empty_s
                       && !redirect_valid && (!data_full_s || pop_now_s);

        req_entry_s       = '{pc: pc_q, instr: 32'h0000_0000, misalign: 1'b0};
        rsp_entry_s       = req_head_s;
        rsp_entry_s.instr = imem_rsp_data;
        mis_entry_s       = '{pc: redirect_pc, instr: NOP_INSTR, misalign: 1'b1};

        // Responses still owed by memory that belong to discarded work.
        pending_s = drop_q + DROP_W'(req_cnt_s);

        pc_d   = pc_q;
        drop_d = drop_q;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
            // A response arriving now is one of the pending ones and is discarded here.
            if (imem_rsp_valid && (pending_s != DROP_ZERO)) begin
                drop_d = pending_s - DROP_ONE;
            end else if (imem_rsp_valid) begin
                drop_d = DROP_ZERO;
            end else begin
                drop_d = pending_s;
            end
        end else begin
            if (req_fire_s) begin
                pc_d = pc_q + PC_INCR;
            end else begin
                pc_d = pc_q;
            end
            if (imem_rsp_valid && (drop_q != DROP_ZERO)) begin
                drop_d = drop_q - DROP_ONE;
            end else begin
                drop_d = drop_q;
            end
        end

        if (redirect_valid) begin
            data_push_s       = misalign_redirect_s;
            data_push_entry_s = mis_entry_s;
        end else begin
            data_push_s       = rsp_accept_s;
            data_push_entry_s = rsp_entry_s;
        end
        data_pop_s = pop_now_s && !redirect_valid;
    end

    // PC and drop-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            drop_q <= DROP_ZERO;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    // PCs of requests issued but not yet answered, oldest first.
    fetch_fifo #(.DEPTH(DEPTH)) u_req_fifo (
        .clk       (clk),
        .rst       (reset),
        .flush     (redirect_valid),
        .push      (req_fire_s),
        .push_data (req_entry_s),
        .pop       (rsp_accept_s),
        .head      (req_head_s),
        .full      (req_full_s),
        .empty     (req_empty_s),
        .count     (req_cnt_s)
    );

    // Returned instructions waiting for decode.
    fetch_fifo #(.DEPTH(DEPTH)) u_data_fifo (
        .clk       (clk),
        .rst       (reset),
        .flush     (redirect_valid),
        .push      (data_push_s),
        .push_data (data_push_entry_s),
        .pop       (data_pop_s),
        .head      (data_head_s),
        .full      (data_full_s),
        .empty     (data_empty_s),
        .count     (data_cnt_s)
    );

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_q;
    assign if_valid       = !data_empty_s;
    assign if_pc          = data_head_s.pc;
    assign if_instr       = data_head_s.instr;
`ifdef INSTR_FETCH_MISALIGN_EN
    assign if_misalign    = data_head_s.misalign;
`else
    assign if_misalign    = 1'b0;
`endif

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of decode and immediate generation. Keeps the program counter, issues in-order word requests to instruction memory, buffers returned instructions in a small FIFO, and presents (pc, instr) pairs to decode over a valid/ready handshake. A branch/jump redirect from execute flushes all in-flight and buffered work and restarts fetch at the new target.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- DEPTH, 2, FIFO entries and maximum outstanding requests (power of two, ≥2)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  request to instruction memory
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response data valid (in order, latency ≥1 cycle)
- imem_rsp_data  in  32  returned instruction word
- redirect_valid  in  1  taken branch/jump from execute
- redirect_pc  in  32  redirect target
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts this cycle
- if_pc  out  32  PC of presented instruction
- if_instr  out  32  presented instruction word
- if_misalign  out  1  presented entry is a misaligned-target fault (only with INSTR_FETCH_MISALIGN_EN; otherwise tied 0)

## Operation
- Credits: outstanding (requested, not yet returned) + FIFO occupancy ≤ DEPTH; imem_req_valid = credit available && !redirect_valid && !halted.
- imem_req_addr = pc register; on req_valid && req_ready, pc <= pc + 4 (wraps modulo 2^32), outstanding +1.
- On imem_rsp_valid: if drop counter > 0, decrement drop counter and discard; else write {pc_of_request, data} into FIFO. Request PCs tracked in order alongside outstanding count.
- if_valid = FIFO non-empty; head pops on if_valid && if_ready. Outputs are FIFO head (registered storage, no bypass).
- Redirect: FIFO flushed, pc <= {redirect_pc[31:2], 2'b00}, drop counter <= outstanding count (including any response arriving the same cycle, which is discarded), no request issued that cycle. Redirect beats a simultaneous pop and simultaneous response.
- Decode holds if_ready low: FIFO fills, credits exhaust, requests stop; no data lost.
- imem_req_ready low: request held stable (valid, addr) until accepted or redirect.

## Timing
- Reset values: pc = RESET_PC, imem_req_valid = 0 during reset, if_valid = 0, if_pc = 0, if_instr = 0, if_misalign = 0, counters 0, halted = 0.
- First request issued the first cycle after reset deasserts.
- Response in cycle N appears on if_valid in cycle N+1.
- Minimum latency request-accept to if_valid: 2 cycles with 1-cycle memory.
- After redirect in cycle R: new request at redirect target in cycle R+1; if_valid low in R+1 at minimum.
- Steady-state throughput 1 instr/cycle with 1-cycle memory and DEPTH ≥ 2.
- Reset asserted mid-operation: all state returns to reset values immediately; late responses after reset are ignored only if they arrive while reset is high.

## Configuration
- INSTR_FETCH_MISALIGN_EN defined: redirect_pc[1:0] != 0 flushes as normal, then enqueues one entry {pc = redirect_pc, instr = 32'h0000_0013, misalign = 1} and sets halted (no further requests) until the next redirect or reset.
- Not defined: redirect_pc[1:0] silently cleared; if_misalign tied 0; no halted state.

## Structure
- fetch_pkg: INSTR_W = 32, NOP_INSTR = 32'h0000_0013, PC_INCR = 4, typedef fetch_entry_t {pc, instr, misalign}.
- One sub-module: fetch_fifo (parameterised by DEPTH, stores fetch_entry_t, push/pop/flush, full/empty, count). A second in-order queue of request PCs reuses fetch_fifo.

## Test plan
- Reset RESET_PC=32'h100, 1-cycle memory, if_ready=1 -> requests 0x100,0x104,0x108 on consecutive cycles; if_pc sequence matches with if_instr equal to memory contents.
- if_ready=0 for 10 cycles -> exactly DEPTH entries buffered, imem_req_valid drops; release -> entries drain in order, none lost or duplicated.
- Redirect to 0x200 with 2 responses outstanding (3-cycle memory) -> both discarded, next if_pc = 0x200.
- Redirect in same cycle as imem_rsp_valid and if_ready pop -> response discarded, FIFO empty next cycle, next request addr = target.
- imem_req_ready low 5 cycles -> imem_req_addr stable at 0x104, pc advances only on acceptance.
- With INSTR_FETCH_MISALIGN_EN, redirect to 0x202 -> single entry if_pc=0x202, if_instr=0x00000013, if_misalign=1, no requests until redirect to 0x300.
